// File: rtl/sdram_cpu_bridge.sv
// CPU byte strobes -> 16-bit toggle req/ack SDRAM port; hit 1 clk, miss 1+ack wait+DATA_DELAY clk, bus_busy stalls the CPU.
// Define SDRAM_BRIDGE_PREFETCH_EN for a second buffer entry filled by a background read of the next word.
module sdram_cpu_bridge #(
    parameter int DATA_DELAY = 5,
    parameter bit PORT_SEL   = 1'b0
) (
    input  logic        clk,
    input  logic        init_n,
    input  logic [23:0] bus_addr,
    input  logic        bus_rd_stb,
    input  logic        bus_wr_stb,
    input  logic [7:0]  bus_din,
    output logic [7:0]  bus_dout,
    output logic        bus_busy,
    output logic [22:0] sd_addr,
    output logic [15:0] sd_din,
    output logic [1:0]  sd_ds,
    output logic        sd_we,
    output logic        sd_req,
    input  logic        sd_req_ack,
    input  logic [15:0] sd_dout,
    output logic        sd_port
);

`ifdef SDRAM_BRIDGE_PREFETCH_EN
    typedef enum logic [2:0] {SYNC, IDLE, RD_ACK, RD_DATA, WR_ACK, PF_ACK, PF_DATA} state_t;
`else
    typedef enum logic [2:0] {SYNC, IDLE, RD_ACK, RD_DATA, WR_ACK} state_t;
`endif

    state_t      state;
    logic [15:0] buf_dat;
    logic [22:0] buf_tag;
    logic        buf_vld;
    logic [3:0]  cnt;
    logic        byte_sel;

    logic        acc_rd;
    logic        acc_wr;
    logic [23:0] acc_addr;
    logic [7:0]  acc_din;
    logic        hit_main;
    logic        ack_match;

`ifdef SDRAM_BRIDGE_PREFETCH_EN
    logic [15:0] pbuf_dat;
    logic [22:0] pbuf_tag;
    logic        pbuf_vld;
    logic        pend_vld;
    logic        pend_we;
    logic [23:0] pend_addr;
    logic [7:0]  pend_din;
    logic        hit_pf;
`endif

    function automatic logic [7:0] pick(input logic [15:0] w, input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction

    assign sd_port   = PORT_SEL;
    assign ack_match = (sd_req_ack == sd_req);

    // A strobe parked during a prefetch is replayed from IDLE exactly like a fresh one.
    always_comb begin
        acc_addr = bus_addr;
        acc_din  = bus_din;
        acc_rd   = bus_rd_stb & ~bus_wr_stb & ~bus_busy;
        acc_wr   = bus_wr_stb & ~bus_busy;
`ifdef SDRAM_BRIDGE_PREFETCH_EN
        if (pend_vld) begin
            acc_addr = pend_addr;
            acc_din  = pend_din;
            acc_rd   = ~pend_we;
            acc_wr   = pend_we;
        end
        hit_pf = pbuf_vld && (pbuf_tag == acc_addr[23:1]);
`endif
        hit_main = buf_vld && (buf_tag == acc_addr[23:1]);
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state    <= SYNC;
            bus_dout <= 8'd0;
            bus_busy <= 1'b1;
            sd_addr  <= 23'd0;
            sd_din   <= 16'd0;
            sd_ds    <= 2'b00;
            sd_we    <= 1'b0;
            sd_req   <= 1'b0;
            buf_dat  <= 16'd0;
            buf_tag  <= 23'd0;
            buf_vld  <= 1'b0;
            cnt      <= 4'd0;
            byte_sel <= 1'b0;
`ifdef SDRAM_BRIDGE_PREFETCH_EN
            pbuf_dat  <= 16'd0;
            pbuf_tag  <= 23'd0;
            pbuf_vld  <= 1'b0;
            pend_vld  <= 1'b0;
            pend_we   <= 1'b0;
            pend_addr <= 24'd0;
            pend_din  <= 8'd0;
`endif
        end else begin
            case (state)
                SYNC: begin
                    sd_req   <= sd_req_ack;
                    bus_busy <= 1'b0;
                    state    <= IDLE;
                end
                IDLE: begin
                    if (acc_wr) begin
                        sd_din   <= {acc_din, acc_din};
                        sd_ds    <= {acc_addr[0], ~acc_addr[0]};
                        sd_we    <= 1'b1;
                        sd_addr  <= acc_addr[23:1];
                        sd_req   <= ~sd_req;
                        bus_busy <= 1'b1;
                        state    <= WR_ACK;
                        if (hit_main) begin
                            if (acc_addr[0]) buf_dat[15:8] <= acc_din;
                            else             buf_dat[7:0]  <= acc_din;
                        end
`ifdef SDRAM_BRIDGE_PREFETCH_EN
                        if (hit_pf) begin
                            if (acc_addr[0]) pbuf_dat[15:8] <= acc_din;
                            else             pbuf_dat[7:0]  <= acc_din;
                        end
                        pend_vld <= 1'b0;
`endif
                    end else if (acc_rd) begin
                        if (hit_main) begin
                            bus_dout <= pick(buf_dat, acc_addr[0]);
                            bus_busy <= 1'b0;
`ifdef SDRAM_BRIDGE_PREFETCH_EN
                        end else if (hit_pf) begin
                            bus_dout <= pick(pbuf_dat, acc_addr[0]);
                            bus_busy <= 1'b0;
                            buf_dat  <= pbuf_dat;
                            buf_tag  <= pbuf_tag;
                            buf_vld  <= pbuf_vld;
                            pbuf_dat <= buf_dat;
                            pbuf_tag <= buf_tag;
                            pbuf_vld <= buf_vld;
`endif
                        end else begin
                            sd_addr  <= acc_addr[23:1];
                            sd_we    <= 1'b0;
                            sd_ds    <= 2'b11;
                            sd_req   <= ~sd_req;
                            bus_busy <= 1'b1;
                            byte_sel <= acc_addr[0];
                            state    <= RD_ACK;
                        end
`ifdef SDRAM_BRIDGE_PREFETCH_EN
                        pend_vld <= 1'b0;
`endif
                    end
                end
                RD_ACK: begin
                    if (ack_match) begin
                        cnt   <= 4'(DATA_DELAY - 1);
                        state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (cnt == 4'd0) begin
                        buf_dat  <= sd_dout;
                        buf_tag  <= sd_addr;
                        buf_vld  <= 1'b1;
                        bus_dout <= pick(sd_dout, byte_sel);
                        bus_busy <= 1'b0;
`ifdef SDRAM_BRIDGE_PREFETCH_EN
                        sd_addr  <= sd_addr + 23'd1;
                        sd_req   <= ~sd_req;
                        state    <= PF_ACK;
`else
                        state    <= IDLE;
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_ACK: begin
                    if (ack_match) begin
                        bus_busy <= 1'b0;
                        sd_we    <= 1'b0;
                        state    <= IDLE;
                    end
                end
`ifdef SDRAM_BRIDGE_PREFETCH_EN
                PF_ACK, PF_DATA: begin
                    // Main-buffer hits are served during the prefetch; anything else waits for it.
                    if (!pend_vld && (acc_rd || acc_wr)) begin
                        if (acc_rd && hit_main) begin
                            bus_dout <= pick(buf_dat, acc_addr[0]);
                        end else begin
                            pend_vld  <= 1'b1;
                            pend_we   <= acc_wr;
                            pend_addr <= bus_addr;
                            pend_din  <= bus_din;
                            bus_busy  <= 1'b1;
                        end
                    end
                    if (state == PF_ACK) begin
                        if (ack_match) begin
                            cnt   <= 4'(DATA_DELAY - 1);
                            state <= PF_DATA;
                        end
                    end else if (cnt == 4'd0) begin
                        pbuf_dat <= sd_dout;
                        pbuf_tag <= sd_addr;
                        pbuf_vld <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
`endif
                default: state <= SYNC;
            endcase
        end
    end

endmodule
